vote_collector: RTL and testbench

- Sequential front end that gathers one ballot per voter over a valid/ready interface.
- Packs the ballots into the flat vector consumed by the voting tally stage: `(2**M)*N` bits, voter i at bits `[i*N +: N]`.
- Presents the packed vector with a valid/ack handshake.
- Sits directly upstream of the voting core: its `ballot` output drives that core's `vote` input.

---
 rtl/vote_collector.sv | 104 ++++++++++
 tb/tb_vote_collector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vote_collector.sv
// Ballot collector: gathers one vote per voter slot and presents
// the packed ballot vector to the tally stage with a valid/ack handshake.
module vote_collector #(
  parameter int N = 2,
  parameter int M = 2,
  parameter logic [N-1:0] DEFAULT_VOTE = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vote_valid,
  output logic               vote_ready,
  input  logic [N-1:0]       vote_in,
  input  logic [M-1:0]       voter_id,
  input  logic               close,
  output logic [(2**M)*N-1:0] ballot,
  output logic               ballot_valid,
  input  logic               ballot_ack,
  output logic               dup_err,
  output logic [M:0]         count
);

  localparam int V = 2 ** M;
  localparam int W = V * N;

  typedef enum logic {COLLECT, FULL} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   ballot_q, ballot_d;
  logic [V-1:0]   voted_q, voted_d;
  logic [M:0]     count_q, count_d;
  logic           valid_q, valid_d;
  logic           dup_q, dup_d;
  logic           hs;

  assign hs = vote_valid && (state_q == COLLECT);

  always_comb begin
    state_d  = state_q;
    ballot_d = ballot_q;
    voted_d  = voted_q;
    count_d  = count_q;
    valid_d  = valid_q;
    dup_d    = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (hs) begin
          if (voted_q[voter_id]) begin
            dup_d = 1'b1;
          end else begin
            for (int i = 0; i < V; i++)
              if (voter_id == M'(i))
                ballot_d[i*N +: N] = vote_in;
            voted_d[voter_id] = 1'b1;
            count_d = count_q + (M+1)'(1);
          end
        end
        if (close || count_d == (M+1)'(V)) begin
          state_d = FULL;
          valid_d = 1'b1;
          // Slots never voted get the default, after this cycle's vote lands
          if (close)
            for (int i = 0; i < V; i++)
              if (!voted_d[i])
                ballot_d[i*N +: N] = DEFAULT_VOTE;
        end
      end
      FULL: begin
        if (ballot_ack) begin
          state_d  = COLLECT;
          ballot_d = '0;
          voted_d  = '0;
          count_d  = '0;
          valid_d  = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= COLLECT;
      ballot_q <= '0;
      voted_q  <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      dup_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ballot_q <= ballot_d;
      voted_q  <= voted_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      dup_q    <= dup_d;
    end
  end

  assign vote_ready   = (state_q == COLLECT);
  assign ballot       = ballot_q;
  assign ballot_valid = valid_q;
  assign dup_err      = dup_q;
  assign count        = count_q;

endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector: N=2/M=2 with DEFAULT_VOTE=2,
// plus an N=3/M=4 instance for slot ordering.
module tb_vote_collector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [1:0] a_vin = '0;
  logic [1:0] a_id = '0;
  logic       a_close = 1'b0;
  logic [7:0] a_ballot;
  logic       a_bvalid;
  logic       a_ack = 1'b0;
  logic       a_dup;
  logic [2:0] a_count;

  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [2:0]  b_vin = '0;
  logic [3:0]  b_id = '0;
  logic        b_close = 1'b0;
  logic [47:0] b_ballot;
  logic        b_bvalid;
  logic        b_ack = 1'b0;
  logic        b_dup;
  logic [4:0]  b_count;

  vote_collector #(.N(2), .M(2), .DEFAULT_VOTE(2'd2)) u_a (
    .clk(clk), .rst(rst),
    .vote_valid(a_valid), .vote_ready(a_ready),
    .vote_in(a_vin), .voter_id(a_id), .close(a_close),
    .ballot(a_ballot), .ballot_valid(a_bvalid),
    .ballot_ack(a_ack), .dup_err(a_dup), .count(a_count)
  );

  vote_collector #(.N(3), .M(4), .DEFAULT_VOTE(3'd0)) u_b (
    .clk(clk), .rst(rst),
    .vote_valid(b_valid), .vote_ready(b_ready),
    .vote_in(b_vin), .voter_id(b_id), .close(b_close),
    .ballot(b_ballot), .ballot_valid(b_bvalid),
    .ballot_ack(b_ack), .dup_err(b_dup), .count(b_count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic vote_a(input logic [1:0] id,
                        input logic [1:0] v,
                        input logic cl);
    a_valid = 1'b1;
    a_id    = id;
    a_vin   = v;
    a_close = cl;
    tick();
    a_valid = 1'b0;
    a_close = 1'b0;
  endtask

  task automatic close_a();
    a_close = 1'b1;
    tick();
    a_close = 1'b0;
  endtask

  logic [47:0] b_exp;
  int dups;

  initial begin
    // Reset state
    rst = 1'b0;
    #2;
    chk("rst_ballot", a_ballot, 8'h00);
    chk("rst_count", a_count, 0);
    chk("rst_bvalid", a_bvalid, 0);
    chk("rst_dup", a_dup, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_ready", a_ready, 1);

    // Full round
    vote_a(2'd0, 2'd1, 1'b0);
    vote_a(2'd1, 2'd2, 1'b0);
    vote_a(2'd2, 2'd1, 1'b0);
    chk("full_bvalid_early", a_bvalid, 0);
    chk("full_count3", a_count, 3);
    vote_a(2'd3, 2'd3, 1'b0);
    chk("full_bvalid", a_bvalid, 1);
    chk("full_ballot", a_ballot, 8'hD9);
    chk("full_count", a_count, 4);
    chk("full_ready", a_ready, 0);

    // Hold with no ack
    a_valid = 1'b1;
    a_id    = 2'd0;
    a_vin   = 2'd3;
    a_close = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_ballot", a_ballot, 8'hD9);
      chk("hold_count", a_count, 4);
      chk("hold_dup", a_dup, 0);
      chk("hold_bvalid", a_bvalid, 1);
    end
    a_close = 1'b0;
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    chk("ack_ballot", a_ballot, 8'h00);
    chk("ack_count", a_count, 0);
    chk("ack_ready", a_ready, 1);
    chk("ack_bvalid", a_bvalid, 0);
    tick();
    a_valid = 1'b0;
    chk("next_round_count", a_count, 1);
    chk("next_round_ballot", a_ballot, 8'h03);

    // Duplicate
    do_reset();
    dups = 0;
    vote_a(2'd0, 2'd1, 1'b0);
    dups += int'(a_dup);
    vote_a(2'd0, 2'd3, 1'b0);
    chk("dup_pulse", a_dup, 1);
    chk("dup_count", a_count, 1);
    vote_a(2'd1, 2'd2, 1'b0);
    chk("dup_clear", a_dup, 0);
    vote_a(2'd2, 2'd2, 1'b0);
    dups += int'(a_dup);
    vote_a(2'd3, 2'd0, 1'b0);
    dups += int'(a_dup);
    chk("dup_others", dups, 0);
    chk("dup_ballot", a_ballot, 8'h29);
    chk("dup_bvalid", a_bvalid, 1);

    // Early close with default fill
    do_reset();
    vote_a(2'd1, 2'd3, 1'b0);
    vote_a(2'd2, 2'd1, 1'b0);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    chk("collect_ack_ign", a_count, 2);
    chk("close_pre_bvalid", a_bvalid, 0);
    close_a();
    chk("close_ballot", a_ballot, 8'h9E);
    chk("close_count", a_count, 2);
    chk("close_bvalid", a_bvalid, 1);

    // Coincident close and vote
    do_reset();
    vote_a(2'd0, 2'd1, 1'b0);
    vote_a(2'd1, 2'd1, 1'b0);
    vote_a(2'd2, 2'd1, 1'b0);
    vote_a(2'd3, 2'd0, 1'b1);
    chk("coin_ballot", a_ballot, 8'h15);
    chk("coin_count", a_count, 4);
    chk("coin_bvalid", a_bvalid, 1);

    // Async reset mid-round
    do_reset();
    vote_a(2'd0, 2'd2, 1'b0);
    vote_a(2'd1, 2'd2, 1'b0);
    vote_a(2'd2, 2'd2, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_ballot", a_ballot, 8'h00);
    chk("arst_count", a_count, 0);
    chk("arst_bvalid", a_bvalid, 0);
    #1;
    rst = 1'b1;
    tick();
    vote_a(2'd3, 2'd2, 1'b0);
    vote_a(2'd2, 2'd3, 1'b0);
    vote_a(2'd1, 2'd0, 1'b0);
    chk("arst_mid", a_bvalid, 0);
    vote_a(2'd0, 2'd1, 1'b0);
    chk("arst_ballot2", a_ballot, 8'hB1);
    chk("arst_count2", a_count, 4);
    chk("arst_bvalid2", a_bvalid, 1);

    // Wide instance, slot ordering
    do_reset();
    b_exp = '0;
    for (int i = 0; i < 16; i++) begin
      b_valid = 1'b1;
      b_id    = 4'(i);
      b_vin   = 3'(i * 3 + 1);
      b_exp[i*3 +: 3] = 3'(i * 3 + 1);
      tick();
      if (i == 14) chk("wide_early", b_bvalid, 0);
    end
    b_valid = 1'b0;
    chk("wide_ballot", b_ballot, b_exp);
    chk("wide_count", b_count, 16);
    chk("wide_bvalid", b_bvalid, 1);
    chk("wide_ready", b_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
